// File: rtl/drum_div_32_u.sv
// drum_div_32_u - sequential approximate unsigned 32-bit divider (DRUM style).
//
// The dividend is reduced to a 12-bit window and the divisor to a 6-bit
// window, each anchored at its leading one with the window LSB forced to 1
// (unbiasing). A 12-iteration restoring division runs on the windows, and
// the small quotient is rescaled by the difference of the window positions.
//
// Handshake: start is accepted only while busy=0 (state IDLE); a and b are
// captured on the accepting edge. busy stays high until the result edge, at
// which done pulses for one cycle together with updated r and dz. A start
// seen while busy is ignored. r and dz hold their value between results.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, sampled while busy=0
//   a      in  32   dividend, captured with an accepted start
//   b      in  32   divisor, captured with an accepted start
//   busy   out  1   operation in flight
//   done   out  1   one-cycle result strobe
//   r      out 32   approximate quotient (all ones on divide by zero)
//   dz     out  1   divide-by-zero flag
module drum_div_32_u (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] r,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

  state_t state, state_next;

  logic [3:0]         cnt;
  logic [31:0]        a_q, b_q;
  logic [11:0]        at_q;
  logic [5:0]         bt_q;
  logic signed [5:0]  s_q;
  logic               dz_q;
  logic [11:0]        at_sh;
  logic [11:0]        q;
  logic [5:0]         rem;

  // Leading-one detection on the captured operands.
  logic [4:0] ka, kb;
  always_comb begin
    ka = '0;
    kb = '0;
    for (int i = 0; i < 32; i++) begin
      if (a_q[i]) ka = 5'(i);
      if (b_q[i]) kb = 5'(i);
    end
  end

  // Window extraction. Shifting the operand right by the window position
  // puts the leading one at the window MSB; the LSB is then forced to 1.
  logic [4:0]        pa, pb;
  logic [11:0]       at_w;
  logic [5:0]        bt_w;
  logic signed [5:0] s_w;
  always_comb begin
    pa   = '0;
    pb   = '0;
    at_w = a_q[11:0];
    bt_w = b_q[5:0];
    if (ka > 5'd11) begin
      pa   = ka - 5'd11;
      at_w = 12'(a_q >> pa) | 12'd1;
    end
    if (kb > 5'd5) begin
      pb   = kb - 5'd5;
      bt_w = 6'(b_q >> pb) | 6'd1;
    end
    s_w = $signed({1'b0, pa}) - $signed({1'b0, pb});
  end

  // One restoring-division step. The remainder is always below the divisor
  // window (<= 63), so the shifted trial value fits in 7 bits and the
  // difference after a successful subtract fits back into 6.
  logic [6:0] trial;
  logic       fits;
  always_comb begin
    trial = {rem, at_sh[11]};
    fits  = (trial >= {1'b0, bt_q});
  end

  // Final rescale of the 12-bit quotient.
  logic [31:0] q_ext, scaled;
  always_comb begin
    q_ext = {20'd0, q};
    if (!s_q[5]) scaled = q_ext << $unsigned(s_q);
    else         scaled = q_ext >> (6'd0 - $unsigned(s_q));
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = DIV;
      DIV:  if (cnt == 4'd11) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      at_q  <= '0;
      bt_q  <= '0;
      s_q   <= '0;
      dz_q  <= 1'b0;
      at_sh <= '0;
      q     <= '0;
      rem   <= '0;
      done  <= 1'b0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        LOAD: begin
          at_q  <= at_w;
          bt_q  <= bt_w;
          s_q   <= s_w;
          dz_q  <= (b_q == 32'd0);
          at_sh <= at_w;
          q     <= '0;
          rem   <= '0;
          cnt   <= '0;
        end
        DIV: begin
          at_sh <= {at_sh[10:0], 1'b0};
          if (fits) begin
            rem <= 6'(trial - {1'b0, bt_q});
            q   <= {q[10:0], 1'b1};
          end else begin
            rem <= trial[5:0];
            q   <= {q[10:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
        end
        FIN: begin
          r    <= dz_q ? 32'hFFFF_FFFF : scaled;
          dz   <= dz_q;
          done <= 1'b1;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
